// File: rtl/board_pkg.sv
// Shared constants, FSM encoding and box index helpers
// for the 2048 move engine.
package board_pkg;

   localparam int CODE_W     = 4;
   localparam int EMPTY_CODE = 0;
   localparam int MAX_CODE   = 15;
   localparam int WIN_CODE   = 11;

   localparam logic [1:0] DIR_LEFT  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LINE,
      ST_FINISH
   } state_t;

   // Box number (row*4+col) of element k of line i,
   // with k=0 being the head the tiles slide toward.
   function automatic logic [3:0] line_box(
      input logic [1:0] d,
      input logic [1:0] i,
      input logic [1:0] k
   );
      logic [3:0] b;
      unique case (d)
         DIR_LEFT:  b = {i, k};
         DIR_RIGHT: b = {i, ~k};
         DIR_UP:    b = {k, i};
         DIR_DOWN:  b = {~k, i};
      endcase
      return b;
   endfunction

   // Box 0 (box1) sits in the top code slot of the packed board.
   function automatic int box_lsb(
      input logic [3:0] b,
      input int         cw
   );
      return (15 - int'(b)) * cw;
   endfunction

endpackage

// File: rtl/board_slider_line.sv
// Combinational 2048 slide/merge of one 4-box line,
// head first.
module line_slide
   import board_pkg::*;
#(
   parameter int P_CODE_W   = 4,
   parameter int P_WIN_CODE = 11
) (
   input  logic [3:0][P_CODE_W-1:0] i_line,
   output logic [3:0][P_CODE_W-1:0] o_line,
   output logic [1:0]               o_merges,
   output logic                     o_win
);

   localparam logic [P_CODE_W-1:0] L_EMPTY =
      P_CODE_W'(EMPTY_CODE);
   localparam logic [P_CODE_W-1:0] L_MAX = '1;
   localparam logic [P_CODE_W-1:0] L_WIN =
      P_CODE_W'(P_WIN_CODE);

   // Compacted line, padded with one empty slot so the
   // pair check never runs off the end.
   logic [P_CODE_W-1:0] w_cmp [0:4];

   // Compact non-empty codes toward the head.
   always_comb begin
      int n;
      for (int k = 0; k < 5; k++) w_cmp[k] = L_EMPTY;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         if (i_line[k] != L_EMPTY) begin
            w_cmp[n] = i_line[k];
            n = n + 1;
         end
      end
   end

   // Merge equal pairs once each, head first; saturated
   // codes never merge.
   always_comb begin
      int m;
      logic skip;
      logic [P_CODE_W-1:0] w_sum;
      o_line   = '0;
      o_merges = 2'd0;
      o_win    = 1'b0;
      m        = 0;
      skip     = 1'b0;
      w_sum    = '0;
      for (int k = 0; k < 4; k++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (w_cmp[k] != L_EMPTY &&
                      w_cmp[k] == w_cmp[k+1] &&
                      w_cmp[k] != L_MAX) begin
            w_sum = w_cmp[k] + P_CODE_W'(1);
            o_line[m[1:0]] = w_sum;
            o_merges = o_merges + 2'd1;
            if (w_sum == L_WIN) o_win = 1'b1;
            skip = 1'b1;
            m = m + 1;
         end else begin
            o_line[m[1:0]] = w_cmp[k];
            m = m + 1;
         end
      end
   end

endmodule

// File: rtl/board_slider.sv
// 2048 move engine: latches a board and slides it one
// line per clock, then reports result and status.
module board_slider
   import board_pkg::*;
#(
   parameter int CODE_W   = board_pkg::CODE_W,
   parameter int WIN_CODE = board_pkg::WIN_CODE
) (
   input  logic                 CLOCK_50,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [1:0]           dir,
   input  logic [16*CODE_W-1:0] board_in,
   output logic [16*CODE_W-1:0] board_out,
   output logic                 busy,
   output logic                 done,
   output logic                 moved,
   output logic [3:0]           merges,
   output logic                 win
);

   state_t r_state;
   state_t w_state_nxt;

   logic [16*CODE_W-1:0] r_work;
   logic [16*CODE_W-1:0] r_orig;
   logic [16*CODE_W-1:0] r_board_out;
   logic [1:0]           r_dir;
   logic [1:0]           r_idx;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_moved;
   logic [3:0]           r_merges;
   logic                 r_win;

   logic [3:0][CODE_W-1:0] w_line_in;
   logic [3:0][CODE_W-1:0] w_line_out;
   logic [1:0]             w_line_merges;
   logic                   w_line_win;
   logic [16*CODE_W-1:0]   w_work_nxt;
   logic                   w_accept;

   // A start in the done cycle is dropped.
   assign w_accept = (r_state == ST_IDLE) && start && !r_done;

   line_slide #(
      .P_CODE_W   (CODE_W),
      .P_WIN_CODE (WIN_CODE)
   ) u_line (
      .i_line   (w_line_in),
      .o_line   (w_line_out),
      .o_merges (w_line_merges),
      .o_win    (w_line_win)
   );

   // Gather the current line from the work board.
   always_comb begin
      w_line_in = '0;
      for (int k = 0; k < 4; k++) begin
         w_line_in[k] = r_work[box_lsb(
            line_box(r_dir, r_idx, 2'(k)), CODE_W) +: CODE_W];
      end
   end

   // Scatter the slid line back into its boxes.
   always_comb begin
      w_work_nxt = r_work;
      for (int k = 0; k < 4; k++) begin
         w_work_nxt[box_lsb(
            line_box(r_dir, r_idx, 2'(k)), CODE_W) +: CODE_W]
            = w_line_out[k];
      end
   end

   // State register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = ST_LINE;
         ST_LINE:   if (r_idx == 2'd3) w_state_nxt = ST_FINISH;
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: latch, per-line update, result publish.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_work      <= '0;
         r_orig      <= '0;
         r_board_out <= '0;
         r_dir       <= DIR_LEFT;
         r_idx       <= 2'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_moved     <= 1'b0;
         r_merges    <= 4'd0;
         r_win       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_work   <= board_in;
                  r_orig   <= board_in;
                  r_dir    <= dir;
                  r_idx    <= 2'd0;
                  r_merges <= 4'd0;
                  r_moved  <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            ST_LINE: begin
               r_work   <= w_work_nxt;
               r_merges <= r_merges + {2'b00, w_line_merges};
               r_win    <= r_win | w_line_win;
               r_idx    <= r_idx + 2'd1;
            end
            ST_FINISH: begin
               r_board_out <= r_work;
               r_moved     <= (r_work != r_orig);
               r_done      <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign board_out = r_board_out;
   assign busy      = r_busy;
   assign done      = r_done;
   assign moved     = r_moved;
   assign merges    = r_merges;
   assign win       = r_win;

endmodule
